// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// cache_pkg : shared widths, FSM state codes and address-field helpers for
//             the 2-way L1 data cache controller.
// Revision  : 1.0
// ============================================================================
package cache_pkg;

   localparam int ADDR_W   = 32;
   localparam int BLOCK_W  = 512;
   localparam int IDX_W    = 6;
   localparam int OFF_W    = 6;
   localparam int TAG_W    = ADDR_W - IDX_W - OFF_W;
   localparam int NUM_SETS = 64;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] COMPARE   = 3'd1;
   localparam logic [2:0] WRITEBACK = 3'd2;
   localparam logic [2:0] ALLOCATE  = 3'd3;
   localparam logic [2:0] REFILL    = 3'd4;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
      return addr[OFF_W +: IDX_W];
   endfunction

endpackage
`default_nettype wire

// File: rtl/l1_tag_array.sv
`default_nettype none
// ============================================================================
// l1_tag_array : per-way tags, valid and dirty bits plus one LRU bit per set.
//                Asynchronous read, synchronous write; status bits clear on rst_n.
// Revision     : 1.0
// ============================================================================
module l1_tag_array
   import cache_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] idx_i,
   output logic [TAG_W-1:0] tag0_o,
   output logic [TAG_W-1:0] tag1_o,
   output logic             valid0_o,
   output logic             valid1_o,
   output logic             dirty0_o,
   output logic             dirty1_o,
   output logic             lru_o,
   input  logic             fill_i,
   input  logic             fill_way_i,
   input  logic [TAG_W-1:0] fill_tag_i,
   input  logic             dirty_set_i,
   input  logic             dirty_way_i,
   input  logic             lru_we_i,
   input  logic             lru_val_i
);

   logic [TAG_W-1:0]    rd_tag [2];
   logic [1:0]          rd_valid;
   logic [1:0]          rd_dirty;
   logic [NUM_SETS-1:0] lru_q;

   for (genvar w = 0; w < 2; w++) begin : g_way
      logic [TAG_W-1:0]    tag_q [NUM_SETS];
      logic [NUM_SETS-1:0] valid_q;
      logic [NUM_SETS-1:0] dirty_q;
      logic                sel_fill;
      logic                sel_dirty;

      assign sel_fill  = fill_i      & (fill_way_i  == 1'(w));
      assign sel_dirty = dirty_set_i & (dirty_way_i == 1'(w));

      // Tags carry no reset: they are meaningless until valid is set.
      always_ff @(posedge clk) begin
         if (sel_fill) tag_q[idx_i] <= fill_tag_i;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
         end else if (sel_fill) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
         end else if (sel_dirty) begin
            dirty_q[idx_i] <= 1'b1;
         end
      end

      assign rd_tag[w]   = tag_q[idx_i];
      assign rd_valid[w] = valid_q[idx_i];
      assign rd_dirty[w] = dirty_q[idx_i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        lru_q        <= '0;
      else if (lru_we_i) lru_q[idx_i] <= lru_val_i;
   end

   assign tag0_o   = rd_tag[0];
   assign tag1_o   = rd_tag[1];
   assign valid0_o = rd_valid[0];
   assign valid1_o = rd_valid[1];
   assign dirty0_o = rd_dirty[0];
   assign dirty1_o = rd_dirty[1];
   assign lru_o    = lru_q[idx_i];

endmodule
`default_nettype wire

// File: rtl/l1_cache_ctrl.sv
`default_nettype none
// ============================================================================
// l1_cache_ctrl : sequencing controller for the 2-way, 64-set L1 data array
//                 (write-back, write-allocate, one request in flight).
//                 Optional hit/miss/write-back counters: L1_CACHE_STATS_EN.
// Revision      : 1.0
// ============================================================================
module l1_cache_ctrl
   import cache_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cpu_req_valid,
   output logic               cpu_req_ready,
   input  logic               cpu_req_rw,
   input  logic [ADDR_W-1:0]  cpu_req_addr,
   input  logic [BLOCK_W-1:0] cpu_req_wdata,
   output logic               cpu_resp_valid,
   output logic [BLOCK_W-1:0] cpu_resp_rdata,
   output logic               mem_req_valid,
   output logic               mem_req_rw,
   output logic [ADDR_W-1:0]  mem_req_addr,
   output logic [BLOCK_W-1:0] mem_req_wdata,
   input  logic               mem_ack,
   input  logic [BLOCK_W-1:0] mem_rdata,
`ifdef L1_CACHE_STATS_EN
   output logic [31:0]        stat_hits,
   output logic [31:0]        stat_misses,
   output logic [31:0]        stat_writebacks,
`endif
   output logic [IDX_W-1:0]   cm_index,
   output logic [BLOCK_W-1:0] cm_data_in,
   output logic               cm_write_en,
   input  logic [BLOCK_W-1:0] cm_data_out,
   output logic               cm_way0_hit,
   output logic               cm_way1_hit,
   output logic               cm_lru_bit
);

   logic [2:0]         state_q, state_d;
   logic               rw_q;
   logic [TAG_W-1:0]   tag_q;
   logic [IDX_W-1:0]   idx_q;
   logic [BLOCK_W-1:0] wdata_q;
   logic [BLOCK_W-1:0] refill_q;
   logic [BLOCK_W-1:0] rdata_q;
   logic               resp_q;
   logic               victim_q;
   logic               first_q;

   logic [TAG_W-1:0]   tag0, tag1;
   logic               valid0, valid1, dirty0, dirty1, lru;
   logic               hit0, hit1, hit, hit_way;
   logic               victim_sel, victim_dirty;
   logic [TAG_W-1:0]   victim_tag;
   logic               fill, dirty_set, lru_we;
   logic               unused_off;

   assign unused_off = ^cpu_req_addr[OFF_W-1:0];

   l1_tag_array u_tags (
      .clk         (clk),
      .rst_n       (rst_n),
      .idx_i       (idx_q),
      .tag0_o      (tag0),
      .tag1_o      (tag1),
      .valid0_o    (valid0),
      .valid1_o    (valid1),
      .dirty0_o    (dirty0),
      .dirty1_o    (dirty1),
      .lru_o       (lru),
      .fill_i      (fill),
      .fill_way_i  (victim_q),
      .fill_tag_i  (tag_q),
      .dirty_set_i (dirty_set),
      .dirty_way_i (hit_way),
      .lru_we_i    (lru_we),
      .lru_val_i   (~hit_way)
   );

   assign hit0    = valid0 & (tag0 == tag_q);
   assign hit1    = valid1 & (tag1 == tag_q);
   assign hit     = hit0 | hit1;
   assign hit_way = ~hit0;

   // Fill an empty way first (way0 if both are empty), otherwise evict LRU.
   assign victim_sel   = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru);
   assign victim_dirty = victim_sel ? (valid1 & dirty1) : (valid0 & dirty0);
   assign victim_tag   = victim_q ? tag1 : tag0;

   assign fill      = (state_q == REFILL);
   assign dirty_set = (state_q == COMPARE) & hit & rw_q;
   assign lru_we    = (state_q == COMPARE) & hit;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (cpu_req_valid) state_d = COMPARE;
         COMPARE:   state_d = hit ? IDLE : (victim_dirty ? WRITEBACK : ALLOCATE);
         WRITEBACK: if (mem_ack) state_d = ALLOCATE;
         ALLOCATE:  if (mem_ack) state_d = REFILL;
         REFILL:    state_d = COMPARE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rw_q     <= 1'b0;
         tag_q    <= '0;
         idx_q    <= '0;
         wdata_q  <= '0;
         refill_q <= '0;
         rdata_q  <= '0;
         resp_q   <= 1'b0;
         victim_q <= 1'b0;
         first_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         resp_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cpu_req_valid) begin
                  rw_q    <= cpu_req_rw;
                  tag_q   <= addr_tag(cpu_req_addr);
                  idx_q   <= addr_index(cpu_req_addr);
                  wdata_q <= cpu_req_wdata;
                  first_q <= 1'b1;
               end
            end
            COMPARE: begin
               first_q <= 1'b0;
               if (hit) begin
                  resp_q  <= 1'b1;
                  rdata_q <= rw_q ? '0 : cm_data_out;
               end else begin
                  victim_q <= victim_sel;
               end
            end
            ALLOCATE: if (mem_ack) refill_q <= mem_rdata;
            default: ;
         endcase
      end
   end

   always_comb begin
      cpu_req_ready = (state_q == IDLE);
      mem_req_valid = 1'b0;
      mem_req_rw    = 1'b0;
      mem_req_addr  = '0;
      mem_req_wdata = '0;
      cm_data_in    = '0;
      cm_write_en   = 1'b0;
      cm_way0_hit   = 1'b0;
      cm_way1_hit   = 1'b0;
      cm_lru_bit    = 1'b0;
      case (state_q)
         COMPARE: begin
            if (hit) begin
               cm_way0_hit = hit0;
               cm_way1_hit = ~hit0;
               if (rw_q) begin
                  cm_write_en = 1'b1;
                  cm_lru_bit  = hit_way;
                  cm_data_in  = wdata_q;
               end
            end
         end
         WRITEBACK: begin
            cm_way0_hit   = ~victim_q;
            cm_way1_hit   = victim_q;
            mem_req_valid = 1'b1;
            mem_req_rw    = 1'b1;
            mem_req_addr  = {victim_tag, idx_q, {OFF_W{1'b0}}};
            mem_req_wdata = cm_data_out;
         end
         ALLOCATE: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {tag_q, idx_q, {OFF_W{1'b0}}};
         end
         REFILL: begin
            cm_write_en = 1'b1;
            cm_lru_bit  = victim_q;
            cm_data_in  = refill_q;
         end
         default: ;
      endcase
   end

   assign cm_index       = idx_q;
   assign cpu_resp_valid = resp_q;
   assign cpu_resp_rdata = rdata_q;

`ifdef L1_CACHE_STATS_EN
   logic [31:0] hits_q, misses_q, wbs_q;

   // The post-refill COMPARE has first_q low, so it is not counted again.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hits_q   <= '0;
         misses_q <= '0;
         wbs_q    <= '0;
      end else begin
         if (state_q == COMPARE && first_q && hit)  hits_q   <= hits_q + 32'd1;
         if (state_q == COMPARE && first_q && !hit) misses_q <= misses_q + 32'd1;
         if (state_q == WRITEBACK && mem_ack)       wbs_q    <= wbs_q + 32'd1;
      end
   end

   assign stat_hits       = hits_q;
   assign stat_misses     = misses_q;
   assign stat_writebacks = wbs_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_l1_cache_ctrl.sv
`default_nettype none
// ============================================================================
// tb_l1_cache_ctrl : directed bench with a set-associative cache/memory model,
//                    a behavioural cache_mem data array and a memory responder.
// Revision         : 1.0
// ============================================================================
module tb_l1_cache_ctrl;

   localparam int BW = 512;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cpu_req_valid = 1'b0;
   logic          cpu_req_ready;
   logic          cpu_req_rw = 1'b0;
   logic [31:0]   cpu_req_addr = '0;
   logic [BW-1:0] cpu_req_wdata = '0;
   logic          cpu_resp_valid;
   logic [BW-1:0] cpu_resp_rdata;
   logic          mem_req_valid, mem_req_rw;
   logic [31:0]   mem_req_addr;
   logic [BW-1:0] mem_req_wdata;
   logic          mem_ack;
   logic [BW-1:0] mem_rdata;
   logic [5:0]    cm_index;
   logic [BW-1:0] cm_data_in, cm_data_out;
   logic          cm_write_en, cm_way0_hit, cm_way1_hit, cm_lru_bit;
`ifdef L1_CACHE_STATS_EN
   logic [31:0]   stat_hits, stat_misses, stat_writebacks;
`endif

   always #5 clk = ~clk;

   l1_cache_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cpu_req_valid  (cpu_req_valid),
      .cpu_req_ready  (cpu_req_ready),
      .cpu_req_rw     (cpu_req_rw),
      .cpu_req_addr   (cpu_req_addr),
      .cpu_req_wdata  (cpu_req_wdata),
      .cpu_resp_valid (cpu_resp_valid),
      .cpu_resp_rdata (cpu_resp_rdata),
      .mem_req_valid  (mem_req_valid),
      .mem_req_rw     (mem_req_rw),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wdata  (mem_req_wdata),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata),
`ifdef L1_CACHE_STATS_EN
      .stat_hits      (stat_hits),
      .stat_misses    (stat_misses),
      .stat_writebacks(stat_writebacks),
`endif
      .cm_index       (cm_index),
      .cm_data_in     (cm_data_in),
      .cm_write_en    (cm_write_en),
      .cm_data_out    (cm_data_out),
      .cm_way0_hit    (cm_way0_hit),
      .cm_way1_hit    (cm_way1_hit),
      .cm_lru_bit     (cm_lru_bit)
   );

   // cache_mem data array
   logic [BW-1:0] cmem [2][64];
   always @(posedge clk) if (cm_write_en) cmem[cm_lru_bit][cm_index] <= cm_data_in;
   assign cm_data_out = cm_way1_hit ? cmem[1][cm_index] : (cm_way0_hit ? cmem[0][cm_index] : '0);

   int n_cmp = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural cache + main memory model ----------------
   typedef struct { bit rw; logic [31:0] addr; logic [BW-1:0] data; } mreq_t;

   logic [19:0]   m_tag   [2][64];
   bit            m_valid [2][64];
   bit            m_dirty [2][64];
   bit            m_lru   [64];
   logic [BW-1:0] m_data  [2][64];
   logic [BW-1:0] mainmem [logic [31:0]];
   mreq_t         exp_mem [$];
   int            m_hits = 0, m_misses = 0, m_wbs = 0;

   function automatic logic [BW-1:0] mem_read(input logic [31:0] a);
      if (mainmem.exists(a)) return mainmem[a];
      return {16{a}};
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 64; s++) begin
         m_valid[0][s] = 0; m_valid[1][s] = 0;
         m_dirty[0][s] = 0; m_dirty[1][s] = 0;
         m_lru[s] = 0;
      end
      m_hits = 0; m_misses = 0; m_wbs = 0;
      exp_mem.delete();
   endtask

   task automatic model_req(input bit rw, input logic [31:0] addr, input logic [BW-1:0] wd,
                            output logic [BW-1:0] rd, output bit was_hit);
      int          idx;
      int          way;
      logic [19:0] t;
      logic [31:0] blk, wb_addr;
      idx = int'(addr[11:6]);
      t   = addr[31:12];
      blk = {addr[31:6], 6'b0};
      if (m_valid[0][idx] && m_tag[0][idx] == t)      begin way = 0; was_hit = 1; end
      else if (m_valid[1][idx] && m_tag[1][idx] == t) begin way = 1; was_hit = 1; end
      else begin
         was_hit = 0;
         if (!m_valid[0][idx])      way = 0;
         else if (!m_valid[1][idx]) way = 1;
         else                       way = int'(m_lru[idx]);
         if (m_valid[way][idx] && m_dirty[way][idx]) begin
            wb_addr = {m_tag[way][idx], addr[11:6], 6'b0};
            exp_mem.push_back('{rw: 1'b1, addr: wb_addr, data: m_data[way][idx]});
            mainmem[wb_addr] = m_data[way][idx];
            m_wbs++;
         end
         exp_mem.push_back('{rw: 1'b0, addr: blk, data: '0});
         m_data[way][idx]  = mem_read(blk);
         m_tag[way][idx]   = t;
         m_valid[way][idx] = 1;
         m_dirty[way][idx] = 0;
      end
      if (was_hit) m_hits++; else m_misses++;
      if (rw) begin
         m_data[way][idx]  = wd;
         m_dirty[way][idx] = 1;
         rd = '0;
      end else begin
         rd = m_data[way][idx];
      end
      m_lru[idx] = (way == 0);
   endtask

   // ---------------- shared driver/monitor state ----------------
   bit            busy = 0;
   int            lat = 0;
   logic [BW-1:0] exp_rdata = '0;
   bit            exp_hit = 0;
   int            ack_delay = 0;
   bit            log_rw [$];
   logic [31:0]   log_addr [$];
   logic [BW-1:0] log_wdata [$];

   // Per-cycle compare of the CPU side against the model expectations
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (busy) lat++;
            if (busy && cpu_resp_valid) begin
               check("resp_rdata", cpu_resp_rdata, exp_rdata);
               if (exp_hit) check("hit_latency", lat, 2);
               busy = 0;
               cpu_req_valid = 1'b0;
            end else if (!busy) begin
               check("spurious_resp", cpu_resp_valid, 0);
               check("cm_write_en_idle", cm_write_en, 0);
            end
            check("req_ready", cpu_req_ready, !busy);
         end
      end
   end

   // Memory responder: checks each request against the model, then acks it
   initial begin
      mreq_t       e;
      bit          rd, aborted;
      logic [31:0] a;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         while (rst_n && mem_req_valid) begin
            if (exp_mem.size() == 0) begin
               check("mem_req_unexpected", mem_req_valid, 0);
               e = '{rw: mem_req_rw, addr: mem_req_addr, data: mem_req_wdata};
            end else begin
               e = exp_mem.pop_front();
            end
            check("mem_req_rw", mem_req_rw, e.rw);
            check("mem_req_addr", mem_req_addr, e.addr);
            if (e.rw) check("mem_req_wdata", mem_req_wdata, e.data);
            log_rw.push_back(mem_req_rw);
            log_addr.push_back(mem_req_addr);
            log_wdata.push_back(mem_req_wdata);
            rd = !mem_req_rw;
            a  = mem_req_addr;
            aborted = 0;
            for (int k = 0; k < ack_delay; k++) begin
               @(negedge clk);
               if (!mem_req_valid) begin aborted = 1; break; end
            end
            if (aborted) begin
               if (rst_n) check("mem_req_held", mem_req_valid, 1);
            end else begin
               mem_ack   = 1'b1;
               mem_rdata = rd ? mem_read(a) : '0;
               @(negedge clk);
               mem_ack   = 1'b0;
               mem_rdata = '0;
               if (rd && rst_n) check("mem_req_drop_after_ack", mem_req_valid, 0);
            end
         end
      end
   end

   task automatic do_req(input bit rw, input logic [31:0] addr, input logic [BW-1:0] wd,
                         input int delay, input bit hold);
      int c;
      model_req(rw, addr, wd, exp_rdata, exp_hit);
      ack_delay = delay;
      log_rw.delete(); log_addr.delete(); log_wdata.delete();
      check("ready_before_req", cpu_req_ready, 1);
      cpu_req_valid = 1'b1;
      cpu_req_rw    = rw;
      cpu_req_addr  = addr;
      cpu_req_wdata = wd;
      @(posedge clk);
      #1;
      busy = 1;
      lat  = 0;
      if (!hold) cpu_req_valid = 1'b0;
      c = 0;
      while (busy && c < 300) begin @(posedge clk); c++; end
      #1;
      if (busy) begin
         check("resp_timeout", cpu_resp_valid, 1);
         busy = 0;
      end
      cpu_req_valid = 1'b0;
      check("mem_reqs_outstanding", exp_mem.size(), 0);
`ifdef L1_CACHE_STATS_EN
      check("stat_hits", stat_hits, m_hits);
      check("stat_misses", stat_misses, m_misses);
      check("stat_writebacks", stat_writebacks, m_wbs);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [BW-1:0] wd7, wd10;
      int c;
      wd7  = {16{32'hC0DE_0007}};
      wd10 = {16{32'hBEEF_0010}};
      mainmem[32'h0000_1040] = {64{8'hA5}};
      mainmem[32'h0000_2040] = {64{8'h22}};
      mainmem[32'h0000_3040] = {64{8'h33}};
      model_reset();

      #12;
      check("rst_ready", cpu_req_ready, 1);
      check("rst_resp_valid", cpu_resp_valid, 0);
      check("rst_mem_req_valid", mem_req_valid, 0);
      check("rst_mem_req_addr", mem_req_addr, 0);
      check("rst_cm_write_en", cm_write_en, 0);
      check("rst_cm_way_hits", {cm_way0_hit, cm_way1_hit}, 0);
      check("rst_cm_index", cm_index, 0);
      check("rst_resp_rdata", cpu_resp_rdata, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // cold read miss, memory answers after 3 cycles
      do_req(0, 32'h0000_1040, '0, 3, 0);
      check("cold_read_data", cpu_resp_rdata, {64{8'hA5}});
      check("cold_mem_addr", log_addr[0], 32'h0000_1040);
`ifdef L1_CACHE_STATS_EN
      check("cold_stat_misses", stat_misses, 1);
`endif
      // read hit
      do_req(0, 32'h0000_1040, '0, 3, 0);
      check("hit_no_mem_req", log_addr.size(), 0);
      // write hit, then two more tags in set 1 force the dirty way0 out
      do_req(1, 32'h0000_1040, {64{8'h5A}}, 2, 0);
      check("write_resp_zero", cpu_resp_rdata, 0);
      do_req(0, 32'h0000_2040, '0, 1, 0);
      check("tag2_data", cpu_resp_rdata, {64{8'h22}});
      do_req(0, 32'h0000_3040, '0, 2, 0);
      check("evict_first_is_wb", log_rw[0], 1);
      check("evict_wb_addr", log_addr[0], 32'h0000_1040);
      check("evict_wb_data", log_wdata[0], {64{8'h5A}});
      check("evict_refill_addr", log_addr[1], 32'h0000_3040);
      check("tag3_data", cpu_resp_rdata, {64{8'h33}});
      // write miss with cpu_req_valid held high throughout
      do_req(1, 32'h0000_4080, wd7, 1, 1);
      do_req(0, 32'h0000_4080, '0, 1, 0);
      check("write_alloc_readback", cpu_resp_rdata, wd7);
      // mem_ack in the same cycle the request rises
      do_req(0, 32'h0000_5080, '0, 0, 0);
      do_req(1, 32'h0000_6080, wd10, 0, 0);
      check("ack0_wb_addr", log_addr[0], 32'h0000_4080);
      do_req(0, 32'h0000_6080, '0, 0, 0);
      check("ack0_readback", cpu_resp_rdata, wd10);

      // reset asserted while ALLOCATE holds mem_req_valid
      model_req(0, 32'h0000_7040, '0, exp_rdata, exp_hit);
      ack_delay = 30;
      cpu_req_valid = 1'b1;
      cpu_req_rw    = 1'b0;
      cpu_req_addr  = 32'h0000_7040;
      @(posedge clk); #1;
      busy = 1; lat = 0;
      cpu_req_valid = 1'b0;
      c = 0;
      while (!mem_req_valid && c < 20) begin @(posedge clk); #1; c++; end
      check("alloc_req_seen", mem_req_valid, 1);
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_mem_req_drop", mem_req_valid, 0);
      check("rst_async_ready", cpu_req_ready, 1);
      check("rst_async_cm_write_en", cm_write_en, 0);
      model_reset();
      busy = 0;
      @(posedge clk); #1;
      check("rst_hold_resp_valid", cpu_resp_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_req(0, 32'h0000_1040, '0, 2, 0);
      check("post_rst_miss_mem", log_addr.size(), 1);
      check("post_rst_data", cpu_resp_rdata, {64{8'h5A}});
      do_req(0, 32'h0000_1040, '0, 2, 0);
      check("post_rst_hit", log_addr.size(), 0);

      repeat (5) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/l1_cache_ctrl.md
Name: l1_cache_ctrl

Overview:
- Sequencing controller for the 2-way, 64-set, 512-bit-block L1 data array cache_mem.
- Holds the tag, valid, dirty and LRU state, and does tag compare.
- Drives cache_mem's index, write, way-select and LRU inputs; runs write-back and refill transfers to main memory.
- Sits between the CPU-side block request port and the memory-side block port; one outstanding request at a time.

Parameters:
- ADDR_W, 32, byte address width.
- BLOCK_W, 512, block width in bits.
- IDX_W, 6, set index width (64 sets).
- OFF_W, 6, byte offset width; TAG_W = ADDR_W-IDX_W-OFF_W = 20.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req_valid  in  1  CPU request valid.
- cpu_req_ready  out  1  controller can accept a request.
- cpu_req_rw  in  1  0=read, 1=write (whole block).
- cpu_req_addr  in  ADDR_W  request byte address; offset bits ignored.
- cpu_req_wdata  in  BLOCK_W  write block.
- cpu_resp_valid  out  1  one-cycle response pulse.
- cpu_resp_rdata  out  BLOCK_W  read block; 0 for writes.
- mem_req_valid  out  1  memory request, held until acked.
- mem_req_rw  out  1  0=block read, 1=block write-back.
- mem_req_addr  out  ADDR_W  block-aligned address.
- mem_req_wdata  out  BLOCK_W  write-back data.
- mem_ack  in  1  memory completion, one cycle.
- mem_rdata  in  BLOCK_W  refill data, valid with mem_ack on reads.
- cm_index  out  IDX_W  set index to cache_mem.
- cm_data_in  out  BLOCK_W  write data to cache_mem.
- cm_write_en  out  1  cache_mem write strobe.
- cm_data_out  in  BLOCK_W  cache_mem read data.
- cm_way0_hit  out  1  way-0 read select.
- cm_way1_hit  out  1  way-1 read select.
- cm_lru_bit  out  1  way targeted by cm_write_en (0=way0).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - All valid, dirty and LRU bits = 0; tags are not reset.
  - State IDLE; cpu_req_ready=1.
  - All other outputs 0.
- Reset asserted mid-operation: abort immediately. mem_req_valid drops, no cache_mem write, no response.
- IDLE:
  - ready=1.
  - On valid&ready, latch rw/addr/wdata and go to COMPARE.
  - ready=0 in every other state; requests presented then are ignored.
- COMPARE:
  - cm_index = latched index.
  - hitN = validN & (tagN==req_tag); if both ways hit, way0 wins.
  - cm_wayN_hit = hitN on a hit.
- Read hit:
  - Register cm_data_out into cpu_resp_rdata.
  - cpu_resp_valid=1 on the next cycle; return to IDLE.
  - Hit latency: 2 cycles from the accept edge.
- Write hit:
  - cm_write_en=1, cm_lru_bit = hit way, cm_data_in = wdata.
  - Set dirty[set][way]; respond next cycle as for a read hit.
- LRU on a hit: lru[set] <= ~hit_way (lru points at the victim).
- Victim selection on a miss:
  - The invalid way if exactly one way is invalid.
  - Way0 if both ways are invalid.
  - Otherwise lru[set].
  - Valid & dirty victim -> WRITEBACK; else -> ALLOCATE.
- WRITEBACK:
  - cm_wayV_hit=1 selects the victim way.
  - mem_req_valid=1, rw=1, addr={victim_tag,index,0}, wdata=cm_data_out.
  - Hold until mem_ack, then go to ALLOCATE.
- ALLOCATE:
  - mem_req_valid=1, rw=0, addr={req_tag,index,0}.
  - On mem_ack, latch mem_rdata and go to REFILL.
  - mem_req_valid deasserts the cycle after mem_ack is sampled.
  - mem_ack in the same cycle as the req rise is legal.
- REFILL:
  - cm_write_en=1, cm_lru_bit=victim, cm_data_in=refill data.
  - tag<=req_tag, valid<=1, dirty<=0; then COMPARE, which now hits.
  - A write miss is thus write-allocate followed by a write hit.
- mem_ack outside WRITEBACK/ALLOCATE: ignored.
- cm_write_en: never asserted outside COMPARE (write hit) and REFILL.

Optional Feature:
- Macro: L1_CACHE_STATS_EN.
- Defined: adds outputs stat_hits, stat_misses, stat_writebacks, each 32-bit, reset 0, wrapping at 2^32.
  - stat_hits increments on the first COMPARE of a request that hits.
  - stat_misses increments on the first COMPARE of a request that misses; the post-refill COMPARE counts neither.
  - stat_writebacks increments on the WRITEBACK mem_ack.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package cache_pkg:
  - Width constants ADDR_W, BLOCK_W, IDX_W, OFF_W, TAG_W, NUM_SETS=64.
  - State enum: IDLE, COMPARE, WRITEBACK, ALLOCATE, REFILL.
  - Address-field extraction functions (tag/index).
- Sub-module l1_tag_array:
  - 2x64 tags, valid/dirty per way, 64 LRU bits.
  - Async-read, sync-write, async-clear on rst_n.
- The FSM and datapath stay in l1_cache_ctrl.

Test Plan:
- Cold read, addr 0x0000_1040 (set 1), memory returns block 0xA5.. after 3 cycles:
  - mem read at 0x0000_1040, REFILL writes way0.
  - resp_valid carries 0xA5.. and stat_misses=1.
- Repeat the read of 0x0000_1040: no mem_req; resp 2 cycles after accept; lru[1]=1.
- Write 0x0000_1040 with 0x5A.., then read tags 0x00002/0x00003 in set 1 (addrs 0x0000_2040, 0x0000_3040):
  - The third tag evicts dirty way0.
  - mem write at 0x0000_1040 with 0x5A.. precedes the refill read.
- cpu_req_valid held high during a miss: ready stays 0; exactly one response per accepted request.
- rst_n low while in ALLOCATE with mem_req_valid=1:
  - mem_req_valid drops asynchronously; all valid bits 0.
  - A following read of 0x0000_1040 misses.
- mem_ack asserted in the same cycle mem_req_valid rises: accepted; mem_req_valid low the next cycle; no duplicate request.
